pipe_hazard_ctl: RTL and testbench

PIPE_HAZARD_CTL -- requirements
Module: pipe_hazard_ctl

---
 rtl/pipe_ctl_pkg.sv | 22 ++
 rtl/fwd_unit.sv | 25 ++
 rtl/pipe_hazard_ctl.sv | 151 +++++++++++++++
 tb/tb_pipe_hazard_ctl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctl_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM state
// encoding, forwarding-select codes and the stall statistic width.
package pipe_ctl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int STALL_CNT_W = 16;

    // Register 0 is hard-wired to zero, so it can never carry a dependency.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// ALU operand forwarding select: EX/MEM result beats MEM/WB result when both
// target the register an EX-stage instruction reads.
module fwd_unit
    import pipe_ctl_pkg::*;
(
    input  logic [4:0] ex_rs_i,
    input  logic [4:0] ex_rt_i,
    input  logic [4:0] mem_dest_i,
    input  logic       mem_regwrite_i,
    input  logic [4:0] wb_dest_i,
    input  logic       wb_regwrite_i,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o
);

    function automatic logic [1:0] select(input logic [4:0] src);
        if (mem_regwrite_i && reg_match(mem_dest_i, src)) return FWD_MEM;
        if (wb_regwrite_i && reg_match(wb_dest_i, src))   return FWD_WB;
        return FWD_REG;
    endfunction

    assign fwd_a_o = select(ex_rs_i);
    assign fwd_b_o = select(ex_rt_i);

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard controller: load-use / RAW stall FSM, branch flush and a
// saturating stall counter. Define HAZ_FORWARD_EN to enable ALU forwarding.
module pipe_hazard_ctl
    import pipe_ctl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic [4:0]             ex_rs,
    input  logic [4:0]             ex_rt,
    input  logic [4:0]             ex_dest,
    input  logic                   ex_memread,
    input  logic                   ex_regwrite,
    input  logic [4:0]             mem_dest,
    input  logic                   mem_regwrite,
    input  logic                   mem_branch_taken,
    input  logic [4:0]             wb_dest,
    input  logic                   wb_regwrite,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   ifid_flush,
    output logic                   idex_bubble,
    output logic                   exmem_flush,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    state_e                 state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [1:0]             hz;
    logic                   stall;
    logic [1:0]             fwd_a_raw, fwd_b_raw;

`ifdef HAZ_FORWARD_EN
    fwd_unit u_fwd (
        .ex_rs_i        (ex_rs),
        .ex_rt_i        (ex_rt),
        .mem_dest_i     (mem_dest),
        .mem_regwrite_i (mem_regwrite),
        .wb_dest_i      (wb_dest),
        .wb_regwrite_i  (wb_regwrite),
        .fwd_a_o        (fwd_a_raw),
        .fwd_b_o        (fwd_b_raw)
    );

    // With forwarding only a load feeding the next instruction needs a bubble.
    always_comb begin
        hz = 2'd0;
        if (ex_memread && (reg_match(ex_rt, id_rs) || reg_match(ex_rt, id_rt)))
            hz = 2'd1;
    end

    logic unused_inputs;
    assign unused_inputs = ^{ex_dest, ex_regwrite};
`else
    assign fwd_a_raw = FWD_REG;
    assign fwd_b_raw = FWD_REG;

    // Without forwarding the consumer waits until the producer reaches WB.
    always_comb begin
        hz = 2'd0;
        if (ex_regwrite && (reg_match(ex_dest, id_rs) || reg_match(ex_dest, id_rt)))
            hz = 2'd2;
        else if (mem_regwrite && (reg_match(mem_dest, id_rs) || reg_match(mem_dest, id_rt)))
            hz = 2'd1;
    end

    logic unused_inputs;
    assign unused_inputs = ^{ex_rs, ex_rt, ex_memread, wb_dest, wb_regwrite};
`endif

    assign fwd_a = rst_n ? fwd_a_raw : FWD_REG;
    assign fwd_b = rst_n ? fwd_b_raw : FWD_REG;

    // NOTE: every output and next-state value gets a default before any branch,
    // so no path through this block leaves a variable unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall       = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;

        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            state_d     = ST_RUN;
            cnt_d       = 2'd0;
        end else if (mem_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            state_d     = ST_FLUSH;
            cnt_d       = 2'd0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (hz != 2'd0) stall = 1'b1;
                    if (hz == 2'd2) begin
                        state_d = ST_STALL;
                        cnt_d   = 2'd1;
                    end
                end
                ST_STALL: begin
                    stall = 1'b1;
                    cnt_d = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) state_d = ST_RUN;
                end
                ST_FLUSH: state_d = ST_RUN;
                default:  state_d = ST_RUN;
            endcase

            if (stall) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    assign stall_cnt_d = (stall && stall_cnt_q != STALL_MAX) ? stall_cnt_q + 1'b1
                                                              : stall_cnt_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            cnt_q       <= 2'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Directed self-checking bench for pipe_hazard_ctl; expectations follow
// HAZ_FORWARD_EN so the same file covers both builds.
module tb_pipe_hazard_ctl;
    import pipe_ctl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
    logic        ex_memread, ex_regwrite, mem_regwrite, mem_branch_taken, wb_regwrite;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cycles;

    int tests = 0;
    int fails = 0;

    pipe_hazard_ctl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .ex_rs            (ex_rs),
        .ex_rt            (ex_rt),
        .ex_dest          (ex_dest),
        .ex_memread       (ex_memread),
        .ex_regwrite      (ex_regwrite),
        .mem_dest         (mem_dest),
        .mem_regwrite     (mem_regwrite),
        .mem_branch_taken (mem_branch_taken),
        .wb_dest          (wb_dest),
        .wb_regwrite      (wb_regwrite),
        .pc_write         (pc_write),
        .ifid_write       (ifid_write),
        .ifid_flush       (ifid_flush),
        .idex_bubble      (idex_bubble),
        .exmem_flush      (exmem_flush),
        .fwd_a            (fwd_a),
        .fwd_b            (fwd_b),
        .stall_cycles     (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        {id_rs, id_rt, ex_rs, ex_rt, ex_dest, mem_dest, wb_dest} = '0;
        {ex_memread, ex_regwrite, mem_regwrite, mem_branch_taken, wb_regwrite} = '0;
    endtask

    // Single-cycle hazard in either build.
    task automatic set_haz1();
`ifdef HAZ_FORWARD_EN
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
`else
        mem_regwrite = 1'b1; mem_dest = 5'd4; id_rs = 5'd4;
`endif
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_pc_write",    pc_write,    16'd0);
        check("rst_ifid_write",  ifid_write,  16'd0);
        check("rst_ifid_flush",  ifid_flush,  16'd1);
        check("rst_idex_bubble", idex_bubble, 16'd1);
        check("rst_exmem_flush", exmem_flush, 16'd1);
        check("rst_fwd_a",       fwd_a,       16'd0);
        check("rst_fwd_b",       fwd_b,       16'd0);
        check("rst_stall_cnt",   stall_cycles, 16'd0);
        rst_n = 1'b1;
        #1;
        check("run_pc_write",    pc_write,    16'd1);
        check("run_ifid_write",  ifid_write,  16'd1);
        check("run_ifid_flush",  ifid_flush,  16'd0);
        check("run_exmem_flush", exmem_flush, 16'd0);
        tick();

        // Register 0 everywhere: no stall, no forward.
        ex_regwrite = 1'b1; ex_memread = 1'b1; mem_regwrite = 1'b1; wb_regwrite = 1'b1;
        #1;
        check("r0_pc_write",    pc_write,    16'd1);
        check("r0_idex_bubble", idex_bubble, 16'd0);
        check("r0_fwd_a",       fwd_a,       16'd0);
        check("r0_fwd_b",       fwd_b,       16'd0);
        tick();
        check("r0_stall_cnt", stall_cycles, 16'd0);
        clear_inputs();

`ifndef HAZ_FORWARD_EN
        // EX-stage RAW: two stall cycles through STALL.
        ex_regwrite = 1'b1; ex_dest = 5'd8; id_rt = 5'd8;
        #1;
        check("nf_ex_pc_write",    pc_write,    16'd0);
        check("nf_ex_ifid_write",  ifid_write,  16'd0);
        check("nf_ex_idex_bubble", idex_bubble, 16'd1);
        check("nf_ex_ifid_flush",  ifid_flush,  16'd0);
        tick();
        clear_inputs();
        #1;
        check("nf_stall_pc_write", pc_write,     16'd0);
        check("nf_stall_bubble",   idex_bubble,  16'd1);
        check("nf_stall_cnt1",     stall_cycles, 16'd1);
        tick();
        check("nf_back_pc_write",  pc_write,     16'd1);
        check("nf_back_bubble",    idex_bubble,  16'd0);
        check("nf_stall_cnt2",     stall_cycles, 16'd2);

        // MEM-stage RAW: one stall cycle.
        set_haz1();
        #1;
        check("nf_mem_pc_write", pc_write, 16'd0);
        tick();
        clear_inputs();
        #1;
        check("nf_mem_release", pc_write,     16'd1);
        check("nf_stall_cnt3",  stall_cycles, 16'd3);

        // Forwarding disabled: selects stay at 00.
        mem_regwrite = 1'b1; mem_dest = 5'd3; wb_regwrite = 1'b1; wb_dest = 5'd3; ex_rs = 5'd3; ex_rt = 5'd3;
        #1;
        check("nf_fwd_a", fwd_a, 16'd0);
        check("nf_fwd_b", fwd_b, 16'd0);
        clear_inputs();

        // Taken branch while in STALL.
        ex_regwrite = 1'b1; ex_dest = 5'd8; id_rs = 5'd8;
        tick();
        clear_inputs();
        mem_branch_taken = 1'b1;
        #1;
        check("br_pc_write",    pc_write,    16'd1);
        check("br_ifid_flush",  ifid_flush,  16'd1);
        check("br_idex_bubble", idex_bubble, 16'd1);
        check("br_exmem_flush", exmem_flush, 16'd1);
        tick();
        mem_branch_taken = 1'b0;
        set_haz1();
        #1;
        check("fl_pc_write",    pc_write,     16'd1);
        check("fl_idex_bubble", idex_bubble,  16'd0);
        check("fl_ifid_flush",  ifid_flush,   16'd0);
        check("fl_stall_cnt",   stall_cycles, 16'd4);
`else
        // Load-use: exactly one stall cycle.
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        #1;
        check("fw_lu_pc_write",    pc_write,    16'd0);
        check("fw_lu_ifid_write",  ifid_write,  16'd0);
        check("fw_lu_idex_bubble", idex_bubble, 16'd1);
        tick();
        clear_inputs();
        #1;
        check("fw_lu_release",   pc_write,     16'd1);
        check("fw_stall_cnt1",   stall_cycles, 16'd1);

        // ALU producer is forwarded, no stall.
        ex_regwrite = 1'b1; ex_dest = 5'd8; id_rt = 5'd8;
        #1;
        check("fw_alu_no_stall", pc_write, 16'd1);
        clear_inputs();

        mem_regwrite = 1'b1; mem_dest = 5'd3; wb_regwrite = 1'b1; wb_dest = 5'd3; ex_rs = 5'd3;
        #1;
        check("fw_a_mem_tie", fwd_a, 16'd2);
        check("fw_b_none",    fwd_b, 16'd0);
        mem_regwrite = 1'b0;
        #1;
        check("fw_a_wb", fwd_a, 16'd1);
        ex_rt = 5'd3;
        #1;
        check("fw_b_wb", fwd_b, 16'd1);
        mem_regwrite = 1'b1; mem_dest = 5'd7; ex_rt = 5'd7;
        #1;
        check("fw_b_mem", fwd_b, 16'd2);
        check("fw_a_wb2", fwd_a, 16'd1);
        clear_inputs();

        // Taken branch overrides a load-use stall.
        set_haz1();
        mem_branch_taken = 1'b1;
        #1;
        check("br_pc_write",    pc_write,    16'd1);
        check("br_ifid_flush",  ifid_flush,  16'd1);
        check("br_idex_bubble", idex_bubble, 16'd1);
        check("br_exmem_flush", exmem_flush, 16'd1);
        tick();
        mem_branch_taken = 1'b0;
        #1;
        check("fl_pc_write",    pc_write,     16'd1);
        check("fl_idex_bubble", idex_bubble,  16'd0);
        check("fl_ifid_flush",  ifid_flush,   16'd0);
        check("fl_stall_cnt",   stall_cycles, 16'd1);
`endif

        // Branch in FLUSH re-enters FLUSH: hazard stays suppressed one more cycle.
        mem_branch_taken = 1'b1;
        #1;
        check("fl_br_exmem_flush", exmem_flush, 16'd1);
        tick();
        mem_branch_taken = 1'b0;
        #1;
        check("fl2_pc_write", pc_write, 16'd1);
        tick();
        check("run_haz_pc_write", pc_write, 16'd0);
        tick();
        clear_inputs();
`ifdef HAZ_FORWARD_EN
        check("fl_after_cnt", stall_cycles, 16'd2);
`else
        check("fl_after_cnt", stall_cycles, 16'd5);
`endif

        // Saturation of the stall statistic.
        set_haz1();
        repeat (65540) tick();
        check("sat_cnt",      stall_cycles, 16'hFFFF);
        check("sat_pc_write", pc_write,     16'd0);
        tick();
        clear_inputs();
        tick();
        check("sat_hold", stall_cycles, 16'hFFFF);

        // Reset in the middle of a stall.
`ifdef HAZ_FORWARD_EN
        set_haz1();
`else
        ex_regwrite = 1'b1; ex_dest = 5'd8; id_rs = 5'd8;
        tick();
        clear_inputs();
`endif
        #1;
        check("mid_stall_pc_write", pc_write, 16'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ifid_flush", ifid_flush, 16'd1);
        tick();
        clear_inputs();
        rst_n = 1'b1;
        #1;
        check("post_rst_pc_write", pc_write,     16'd1);
        check("post_rst_cnt",      stall_cycles, 16'd0);

        // Reset in the middle of FLUSH: first cycle afterwards honours hazards.
        mem_branch_taken = 1'b1;
        tick();
        mem_branch_taken = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_haz1();
        #1;
        check("post_flush_rst_run", pc_write, 16'd0);
        tick();
        clear_inputs();
        check("post_flush_rst_cnt", stall_cycles, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
